// File: rtl/branch_resolve_unit.sv
// Branch resolution for the ID stage: decides taken/not-taken from comparator flags,
// stalls for forwarded operands, waits for the delay slot, then pulses a PC redirect.
module branch_resolve_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic [31:0]       br_target,
  input  logic              opnd_ready,
  input  logic              equal,
  input  logic              ltz,
  input  logic              eqz,
  input  logic              ds_valid,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] BR_BEQ  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] BR_BNE  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] BR_BLEZ = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] BR_BGTZ = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] BR_BLTZ = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] BR_BGEZ = TYPE_W'(5);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    WAIT_DS   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                rv_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [CNT_W-1:0]    br_cnt_d, taken_cnt_d;
  logic                eval;
  logic                eval_taken;
  logic [TYPE_W-1:0]   eval_type;
  logic [ADDR_W-1:0]   eval_tgt;
  logic                stall_raw;

  // Taken decision from the live comparator flags; types 6/7 never taken.
  function automatic logic branch_taken(input logic [TYPE_W-1:0] t,
                                        input logic eq, input logic lt, input logic ez);
    logic tk;
    tk = 1'b0;
    case (t)
      BR_BEQ:  tk = eq;
      BR_BNE:  tk = !eq;
      BR_BLEZ: tk = lt | ez;
      BR_BGTZ: tk = !lt & !ez;
      BR_BLTZ: tk = lt;
      BR_BGEZ: tk = !lt;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // Next-state, datapath and stall decode
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    tgt_d       = tgt_q;
    rv_d        = 1'b0;
    pc_d        = redirect_pc;
    br_cnt_d    = br_cnt;
    taken_cnt_d = taken_cnt;
    stall_raw   = 1'b0;
    eval        = 1'b0;
    eval_type   = br_type;
    eval_tgt    = br_target;
    eval_taken  = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_valid) begin
            if (opnd_ready) begin
              eval = 1'b1;
            end else begin
              stall_raw = 1'b1;
              type_d    = br_type;
              tgt_d     = br_target;
              state_d   = WAIT_OPND;
            end
          end
        end
        WAIT_OPND: begin
          if (opnd_ready) begin
            eval      = 1'b1;
            eval_type = type_q;
            eval_tgt  = tgt_q;
          end else begin
            stall_raw = 1'b1;
          end
        end
        WAIT_DS: begin
          if (ds_valid) begin
            rv_d    = 1'b1;
            pc_d    = tgt_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (eval) begin
      eval_taken = branch_taken(eval_type, equal, ltz, eqz);
      state_d    = IDLE;
      if (eval_type <= BR_BGEZ && br_cnt != '1)
        br_cnt_d = br_cnt + CNT_W'(1);
      if (eval_taken) begin
        if (taken_cnt != '1)
          taken_cnt_d = taken_cnt + CNT_W'(1);
        tgt_d = eval_tgt;
        if (ds_valid) begin
          rv_d = 1'b1;
          pc_d = eval_tgt;
        end else begin
          state_d = WAIT_DS;
        end
      end
    end

    // Clear beats any same-cycle increment.
    if (cnt_clr) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end

    stall = stall_raw & reset;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      type_q         <= '0;
      tgt_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_cnt         <= '0;
      taken_cnt      <= '0;
    end else begin
      state_q        <= state_d;
      type_q         <= type_d;
      tgt_q          <= tgt_d;
      redirect_valid <= rv_d;
      redirect_pc    <= pc_d;
      br_cnt         <= br_cnt_d;
      taken_cnt      <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// compared against a transaction-level model driven by signed operand values.
module tb_branch_resolve_unit;

  localparam int unsigned CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              br_valid;
  logic [2:0]        br_type;
  logic [31:0]       br_target;
  logic              opnd_ready;
  logic              equal;
  logic              ltz;
  logic              eqz;
  logic              ds_valid;
  logic              flush;
  logic              cnt_clr;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .br_target      (br_target),
    .opnd_ready     (opnd_ready),
    .equal          (equal),
    .ltz            (ltz),
    .eqz            (eqz),
    .ds_valid       (ds_valid),
    .flush          (flush),
    .cnt_clr        (cnt_clr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;
  int rv_seen = 0;

  // Current stimulus, kept as operand values rather than flags
  bit          c_bv, c_ordy, c_dsv, c_fl, c_clr;
  int          c_ty, c_a, c_b;
  logic [31:0] c_tg;

  // Model: at most one branch in flight, waiting either for operands or its delay slot
  bit          m_wait_opnd, m_wait_ds, m_rv;
  int          m_type, m_br, m_tk;
  logic [31:0] m_tgt, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit decide(input int t, input int a, input int b);
    case (t)
      0: return a == b;
      1: return a != b;
      2: return a <= 0;
      3: return a > 0;
      4: return a < 0;
      5: return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int x);
    return (x < MAXC) ? x + 1 : MAXC;
  endfunction

  function automatic bit model_stall();
    return !c_fl && !c_ordy && (m_wait_opnd || (!m_wait_ds && c_bv));
  endfunction

  task automatic model_reset();
    m_wait_opnd = 0; m_wait_ds = 0; m_rv = 0;
    m_type = 0; m_br = 0; m_tk = 0; m_tgt = '0; m_pc = '0;
  endtask

  task automatic model_step();
    int t;
    logic [31:0] tg;
    m_rv = 0;
    if (c_fl) begin
      m_wait_opnd = 0;
      m_wait_ds   = 0;
    end else if (m_wait_ds) begin
      if (c_dsv) begin
        m_rv = 1; m_pc = m_tgt; m_wait_ds = 0;
      end
    end else if (m_wait_opnd || c_bv) begin
      if (!c_ordy) begin
        if (!m_wait_opnd) begin
          m_type = c_ty; m_tgt = c_tg; m_wait_opnd = 1;
        end
      end else begin
        t  = m_wait_opnd ? m_type : c_ty;
        tg = m_wait_opnd ? m_tgt : c_tg;
        m_wait_opnd = 0;
        if (t < 6) m_br = sat_inc(m_br);
        if (decide(t, c_a, c_b)) begin
          m_tk  = sat_inc(m_tk);
          m_tgt = tg;
          if (c_dsv) begin
            m_rv = 1; m_pc = tg;
          end else begin
            m_wait_ds = 1;
          end
        end
      end
    end
    if (c_clr) begin
      m_br = 0; m_tk = 0;
    end
  endtask

  // One clock: drive at negedge, check stall, advance model at posedge, check outputs
  task automatic run_cycle(input bit bv, input int ty, input logic [31:0] tg, input bit ordy,
                           input int a, input int b, input bit dsv, input bit fl, input bit clr);
    @(negedge clk);
    c_bv = bv; c_ty = ty; c_tg = tg; c_ordy = ordy; c_a = a; c_b = b;
    c_dsv = dsv; c_fl = fl; c_clr = clr;
    br_valid   = bv;
    br_type    = 3'(ty);
    br_target  = tg;
    opnd_ready = ordy;
    equal      = (a == b);
    ltz        = (a < 0);
    eqz        = (a == 0);
    ds_valid   = dsv;
    flush      = fl;
    cnt_clr    = clr;
    #1;
    check("stall", 32'(stall), 32'(model_stall()));
    if (stall) stall_seen++;
    @(posedge clk);
    model_step();
    #1;
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check("redirect_pc", redirect_pc, m_pc);
    check("br_cnt", 32'(br_cnt), 32'(m_br));
    check("taken_cnt", 32'(taken_cnt), 32'(m_tk));
    if (redirect_valid) rv_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, '0, 1, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 1;
      2: return -1;
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    reset = 1'b0;
    br_valid = 0; br_type = '0; br_target = '0; opnd_ready = 0;
    equal = 0; ltz = 0; eqz = 0; ds_valid = 0; flush = 0; cnt_clr = 0;
    c_bv = 0; c_ordy = 0; c_dsv = 0; c_fl = 0; c_clr = 0; c_ty = 0; c_a = 0; c_b = 0; c_tg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rv", 32'(redirect_valid), 32'd0);
    check("reset_pc", redirect_pc, 32'd0);
    check("reset_br", 32'(br_cnt), 32'd0);
    check("reset_tk", 32'(taken_cnt), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: taken BEQ with delay slot in the same cycle
    run_cycle(1, 0, 32'h0000_3010, 1, 5, 5, 1, 0, 0);
    check("t1_rv", 32'(redirect_valid), 32'd1);
    check("t1_pc", redirect_pc, 32'h0000_3010);
    check("t1_br", 32'(br_cnt), 32'd1);
    check("t1_tk", 32'(taken_cnt), 32'd1);
    idle(1);

    // 2: BNE with equal operands is not taken
    stall_seen = 0; rv_seen = 0;
    run_cycle(1, 1, 32'h0000_4000, 1, 7, 7, 1, 0, 0);
    idle(2);
    check("t2_stall", 32'(stall_seen), 32'd0);
    check("t2_rv", 32'(rv_seen), 32'd0);
    check("t2_br", 32'(br_cnt), 32'd2);
    check("t2_tk", 32'(taken_cnt), 32'd1);

    // 3: BGTZ waits 3 cycles for operands, then 2 cycles for the delay slot
    stall_seen = 0; rv_seen = 0;
    run_cycle(1, 3, 32'h0000_5004, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 32'hdead_beec, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 32'hdead_beec, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, '0, 1, 9, 3, 0, 0, 0);
    run_cycle(1, 0, '0, 1, 1, 1, 0, 0, 0);
    run_cycle(0, 0, '0, 1, 0, 0, 1, 0, 0);
    check("t3_pulse_pc", redirect_pc, 32'h0000_5004);
    idle(2);
    check("t3_stall_cycles", 32'(stall_seen), 32'd3);
    check("t3_pulses", 32'(rv_seen), 32'd1);

    // 4: flush discards a taken BLTZ waiting for its delay slot
    rv_seen = 0;
    run_cycle(1, 4, 32'h0000_6000, 1, -3, 0, 0, 0, 0);
    run_cycle(0, 0, '0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, '0, 1, 0, 0, 1, 0, 0);
    check("t4_pulses", 32'(rv_seen), 32'd0);

    // 5: saturation at all-ones, then clear beats a taken branch
    run_cycle(0, 0, '0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) run_cycle(1, 0, 32'(i * 4), 1, 2, 2, 1, 0, 0);
    check("t5_br_max", 32'(br_cnt), 32'd15);
    check("t5_tk_max", 32'(taken_cnt), 32'd15);
    for (int i = 0; i < 2; i++) run_cycle(1, 0, 32'h100, 1, 2, 2, 1, 0, 0);
    check("t5_br_sat", 32'(br_cnt), 32'd15);
    check("t5_tk_sat", 32'(taken_cnt), 32'd15);
    run_cycle(1, 0, 32'h200, 1, 2, 2, 1, 0, 1);
    check("t5_br_clr", 32'(br_cnt), 32'd0);
    check("t5_tk_clr", 32'(taken_cnt), 32'd0);
    idle(1);

    // 6: async reset while stalled in operand wait
    run_cycle(1, 0, 32'h0000_7000, 1, 4, 4, 1, 0, 0);
    run_cycle(1, 2, 32'h0000_8000, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, '0, 0, 0, 0, 0, 0, 0);
    check("t6_pre_stall", 32'(stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_rv", 32'(redirect_valid), 32'd0);
    check("t6_br", 32'(br_cnt), 32'd0);
    check("t6_tk", 32'(taken_cnt), 32'd0);
    check("t6_pc", redirect_pc, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rv_seen = 0;
    run_cycle(0, 0, '0, 1, 0, 0, 1, 0, 0);
    run_cycle(0, 0, '0, 1, 0, 0, 1, 0, 0);
    check("t6_no_pulse", 32'(rv_seen), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 1) == 0) ? a : pick_operand();
      run_cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                $urandom & 32'hffff_fffc, $urandom_range(0, 9) < 6, a, b,
                $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
                $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
